tt_tile_ena_seq: RTL

- Per-tile enable/reset sequencer. Sits directly upstream of one user module (tt_um_*) and between it and the mux spine.
- Decodes the controller's select broadcast and sequences the user module's ena, clock-gate enable and rst_n.
- Gates spine inputs to the user module and gates the user module's outputs back onto the shared spine.
- Guarantees the user-module contract: while ena=0, inputs are 0, rst_n=0 and the clock is stopped.

---
 rtl/tt_tile_pkg.sv | 6 +
 rtl/tt_tile_gate.sv | 20 ++
 rtl/tt_tile_ena_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/tt_tile_pkg.sv
// tt_tile_pkg: shared types and constants for the tile enable/reset sequencer
package tt_tile_pkg;
  localparam int CNT_W = 4;
  localparam int ADDR_W_DEF = 10;
  typedef enum logic [1:0] {ST_OFF, ST_RST, ST_RUN, ST_DRAIN} state_e;
endpackage

// File: rtl/tt_tile_gate.sv
// tt_tile_gate: combinational gating of spine inputs and user outputs keyed on ena
module tt_tile_gate (
  input  logic       ena_i,
  input  logic [7:0] ui_i,
  input  logic [7:0] uio_i,
  input  logic [7:0] um_uo_i,
  input  logic [7:0] um_uio_out_i,
  input  logic [7:0] um_uio_oe_i,
  output logic [7:0] um_ui_o,
  output logic [7:0] um_uio_o,
  output logic [7:0] uo_o,
  output logic [7:0] uio_out_o,
  output logic [7:0] uio_oe_o
);
  assign um_ui_o   = ena_i ? ui_i : '0;
  assign um_uio_o  = ena_i ? uio_i : '0;
  assign uo_o      = ena_i ? um_uo_i : '0;
  assign uio_oe_o  = ena_i ? um_uio_oe_i : '0;
  assign uio_out_o = ena_i ? (um_uio_out_i & um_uio_oe_i) : '0;
endmodule

// File: rtl/tt_tile_ena_seq.sv
// tt_tile_ena_seq: per-tile select decode and ena/clock-gate/reset sequencing for one user module
module tt_tile_ena_seq
  import tt_tile_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] TILE_ADDR    = '0,
  parameter int                RST_CYCLES   = 4,
  parameter int                DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_stb,
  input  logic [ADDR_W-1:0] sel_addr,
  input  logic              sel_off,
  input  logic              usr_rst_n,
  input  logic [7:0]        ui_in,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic              um_ena,
  output logic              um_clk_en,
  output logic              um_rst_n,
  output logic [7:0]        um_ui_in,
  output logic [7:0]        um_uio_in,
  input  logic [7:0]        um_uo_out,
  input  logic [7:0]        um_uio_out,
  input  logic [7:0]        um_uio_oe
);
  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             ena_q, clk_en_q, rst_n_q;
  // sel_off beats any strobe; a strobe selects only on an address match
  assign sel_d = sel_off ? 1'b0 : sel_stb ? (sel_addr == TILE_ADDR) : sel_q;
  // next state: deselect always drains first, DRAIN is never aborted by reselect
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: if (sel_q) begin
        state_d = ST_RST;
        cnt_d   = RST_LOAD;
      end
      ST_RST: if (!sel_q) begin
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_LOAD;
      end else if (cnt_q == '0) begin
        if (usr_rst_n) state_d = ST_RUN;
      end else cnt_d = cnt_q - CNT_W'(1);
      ST_RUN: if (!sel_q) begin
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_LOAD;
      end else if (!usr_rst_n) begin
        state_d = ST_RST;
        cnt_d   = RST_LOAD;
      end
      ST_DRAIN: if (cnt_q == '0) state_d = ST_OFF;
        else cnt_d = cnt_q - CNT_W'(1);
    endcase
  end
  // state, counter, select and registered control outputs; rst_n forces everything off at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      ena_q    <= 1'b0;
      clk_en_q <= 1'b0;
      rst_n_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      ena_q    <= state_d != ST_OFF;
      clk_en_q <= state_d != ST_OFF;
      rst_n_q  <= state_d == ST_RUN;
    end
  end
  assign um_ena    = ena_q;
  assign um_clk_en = clk_en_q;
  assign um_rst_n  = rst_n_q;
  tt_tile_gate u_gate (
    .ena_i        (ena_q),
    .ui_i         (ui_in),
    .uio_i        (uio_in),
    .um_uo_i      (um_uo_out),
    .um_uio_out_i (um_uio_out),
    .um_uio_oe_i  (um_uio_oe),
    .um_ui_o      (um_ui_in),
    .um_uio_o     (um_uio_in),
    .uo_o         (uo_out),
    .uio_out_o    (uio_out),
    .uio_oe_o     (uio_oe)
  );
  a_off_quiet: assert property (@(posedge clk) disable iff (!rst_n) !um_ena |-> (!um_rst_n && !um_clk_en));
  a_rst_run:   assert property (@(posedge clk) disable iff (!rst_n) um_rst_n |-> state_q == ST_RUN);
endmodule
